or1200_vld_top: RTL and testbench



---
 rtl/or1200_vld_top_if.sv | 21 ++
 rtl/or1200_vld_top.sv | 203 ++++++++++++++++++++
 tb/tb_or1200_vld_top.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/or1200_vld_top_if.sv
// Byte-read memory port used by the VLD bit reader to prefetch entropy-coded data.
interface or1200_vld_top_if;
   logic        load_byte_o;
   logic [31:0] vlx_addr_o;
   logic [31:0] dat_i;
   logic        ack_i;

   modport master (
      output load_byte_o,
      output vlx_addr_o,
      input  dat_i,
      input  ack_i
   );

   modport slave (
      input  load_byte_o,
      input  vlx_addr_o,
      output dat_i,
      output ack_i
   );
endinterface

// File: rtl/or1200_vld_top.sv
// VLD bit reader: prefetches bytes, strips 0xFF/0x00 stuffing, detects markers,
// and serves 0..16-bit get-bits requests to the CPU, stalling until bits are buffered.
module or1200_vld_top (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              get_bit_op_i,
   input  logic [4:0]        num_bits_to_read_i,
   output logic [31:0]       bits_o,
   output logic              stall_cpu_o,
   or1200_vld_top_if.master  mem,
   input  logic              spr_cs,
   input  logic              spr_write,
   input  logic [1:0]        spr_addr,
   input  logic [31:0]       spr_dat_i,
   output logic [31:0]       spr_dat_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned FW = 6;
   localparam int unsigned NW = 5;
   localparam int unsigned BW = 8;

   localparam logic [FW-1:0] FILL_FULL  = FW'(DW);
   localparam logic [FW-1:0] FILL_ROOM  = FW'(DW - BW);
   localparam logic [FW-1:0] FILL_BYTE  = FW'(BW);
   localparam logic [DW-1:0] ONES       = '1;
   localparam logic [BW-1:0] BYTE_FF    = 8'hFF;
   localparam logic [BW-1:0] BYTE_00    = 8'h00;

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

   state_e          state_q, state_d;
   logic            load_q, load_d;
   logic [DW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   buf_q, buf_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic            prev_ff_q, prev_ff_d;
   logic            marker_seen_q, marker_seen_d;
   logic [BW-1:0]   marker_byte_q, marker_byte_d;
   logic            enabled_q, enabled_d;
   logic            discard_q, discard_d;
   logic            pend_q, pend_d;
   logic [NW-1:0]   pend_n_q, pend_n_d;
   logic [DW-1:0]   bits_q, bits_d;

   logic            drain;
   logic [NW-1:0]   get_n;
   logic [FW-1:0]   shamt;
   logic [DW-1:0]   valid_mask;
   logic [DW-1:0]   padded;
   logic [BW-1:0]   byte_v;
   logic            addr_wr;
   logic            stat_wr;

   // Next-state: consume for a get first, then fetch/insert, then SPR writes override.
   always_comb begin
      state_d       = state_q;
      load_d        = load_q;
      addr_d        = addr_q;
      buf_d         = buf_q;
      fill_d        = fill_q;
      prev_ff_d     = prev_ff_q;
      marker_seen_d = marker_seen_q;
      marker_byte_d = marker_byte_q;
      enabled_d     = enabled_q;
      discard_d     = discard_q;
      pend_d        = pend_q;
      pend_n_d      = pend_n_q;
      bits_d        = bits_q;

      drain      = marker_seen_q | ~enabled_q;
      get_n      = pend_q ? pend_n_q : num_bits_to_read_i;
      shamt      = FILL_FULL - FW'(get_n);
      valid_mask = ~(ONES >> fill_q);
      padded     = (buf_q & valid_mask) | ~valid_mask;
      byte_v     = mem.dat_i[BW-1:0];
      addr_wr    = spr_cs & spr_write & spr_addr[1];
      stat_wr    = spr_cs & spr_write & ~spr_addr[1];

      // Get: extract when enough bits, 1-pad in drain mode, otherwise hold pending.
      if (get_bit_op_i | pend_q) begin
         if (fill_q >= FW'(get_n)) begin
            bits_d = buf_q >> shamt;
            buf_d  = buf_q << get_n;
            fill_d = fill_q - FW'(get_n);
            pend_d = 1'b0;
         end else if (drain) begin
            bits_d = padded >> shamt;
            buf_d  = '0;
            fill_d = '0;
            pend_d = 1'b0;
         end else begin
            pend_d   = 1'b1;
            pend_n_d = get_n;
         end
      end

      // Fetch FSM with destuffing of the accepted byte.
      case (state_q)
         S_IDLE: begin
            if (enabled_q & ~marker_seen_q & (fill_q <= FILL_ROOM)) begin
               state_d = S_REQ;
               load_d  = 1'b1;
            end
         end
         S_REQ: begin
            if (mem.ack_i) begin
               state_d   = S_IDLE;
               load_d    = 1'b0;
               discard_d = 1'b0;
               if (!discard_q && !addr_wr) begin
                  addr_d = addr_q + 32'd1;
                  if (!prev_ff_q) begin
                     buf_d     = buf_d | ({byte_v, {(DW-BW){1'b0}}} >> fill_d);
                     fill_d    = fill_d + FILL_BYTE;
                     prev_ff_d = (byte_v == BYTE_FF);
                  end else if (byte_v == BYTE_00) begin
                     prev_ff_d = 1'b0;
                  end else begin
                     fill_d        = (fill_d >= FILL_BYTE) ? fill_d - FILL_BYTE : '0;
                     buf_d         = buf_d & ~(ONES >> fill_d);
                     marker_seen_d = 1'b1;
                     marker_byte_d = byte_v;
                     prev_ff_d     = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            load_d  = 1'b0;
         end
      endcase

      // Address write restarts the stream; an in-flight read is left to finish and dropped.
      if (addr_wr) begin
         addr_d        = spr_dat_i;
         buf_d         = '0;
         fill_d        = '0;
         prev_ff_d     = 1'b0;
         marker_seen_d = 1'b0;
         enabled_d     = 1'b1;
         discard_d     = (state_q == S_REQ) & ~mem.ack_i;
      end

      // Status write acknowledges a marker so fetching can resume.
      if (stat_wr) begin
         marker_seen_d = 1'b0;
         marker_byte_d = '0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         load_q        <= 1'b0;
         addr_q        <= '0;
         buf_q         <= '0;
         fill_q        <= '0;
         prev_ff_q     <= 1'b0;
         marker_seen_q <= 1'b0;
         marker_byte_q <= '0;
         enabled_q     <= 1'b0;
         discard_q     <= 1'b0;
         pend_q        <= 1'b0;
         pend_n_q      <= '0;
         bits_q        <= '0;
      end else begin
         state_q       <= state_d;
         load_q        <= load_d;
         addr_q        <= addr_d;
         buf_q         <= buf_d;
         fill_q        <= fill_d;
         prev_ff_q     <= prev_ff_d;
         marker_seen_q <= marker_seen_d;
         marker_byte_q <= marker_byte_d;
         enabled_q     <= enabled_d;
         discard_q     <= discard_d;
         pend_q        <= pend_d;
         pend_n_q      <= pend_n_d;
         bits_q        <= bits_d;
      end
   end

   assign bits_o          = bits_q;
   assign stall_cpu_o     = get_bit_op_i | pend_q;
   assign mem.load_byte_o = load_q;
   assign mem.vlx_addr_o  = addr_q;

   // SPR read mux: address register or status word.
   always_comb begin
      spr_dat_o = '0;
      if (spr_cs) begin
         spr_dat_o = spr_addr[1] ? addr_q
                                 : {16'h0000, marker_byte_q, marker_seen_q, 1'b0, fill_q};
      end
   end

   logic unused_ok;
   assign unused_ok = ^{mem.dat_i[DW-1:BW], spr_addr[0]};

endmodule

// File: tb/tb_or1200_vld_top.sv
// Bench for or1200_vld_top: bit-queue reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_or1200_vld_top;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        get_bit_op_i = 1'b0;
   logic [4:0]  num_bits_to_read_i = '0;
   logic [31:0] bits_o;
   logic        stall_cpu_o;
   logic        spr_cs = 1'b1;
   logic        spr_write = 1'b0;
   logic [1:0]  spr_addr = 2'b00;
   logic [31:0] spr_dat_i = '0;
   logic [31:0] spr_dat_o;

   or1200_vld_top_if mem_if();

   or1200_vld_top dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .get_bit_op_i       (get_bit_op_i),
      .num_bits_to_read_i (num_bits_to_read_i),
      .bits_o             (bits_o),
      .stall_cpu_o        (stall_cpu_o),
      .mem                (mem_if),
      .spr_cs             (spr_cs),
      .spr_write          (spr_write),
      .spr_addr           (spr_addr),
      .spr_dat_i          (spr_dat_i),
      .spr_dat_o          (spr_dat_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte memory and responder with programmable latency and hold.
   logic [7:0] mem_a [int unsigned];
   int lat  = 0;
   bit hold = 1'b0;
   int cnt  = 0;

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (mem_a.exists(a)) return mem_a[a];
      return 8'h00;
   endfunction

   always @(posedge clk) begin
      #1;
      if (!mem_if.load_byte_o || mem_if.ack_i) begin
         mem_if.ack_i = 1'b0;
         cnt = 0;
      end else if (!hold) begin
         if (cnt >= lat) begin
            mem_if.ack_i = 1'b1;
            mem_if.dat_i = {24'hA5A5A5, rd(mem_if.vlx_addr_o)};
         end else begin
            cnt++;
         end
      end
   end

   // Reference model: the buffered bitstream is a plain queue of bits.
   bit          mq[$];
   logic        m_req, m_pend, m_prev, m_mk, m_en, m_disc;
   logic [4:0]  m_pn;
   logic [7:0]  m_mb;
   logic [31:0] m_bits, m_addr;

   always @(posedge clk) begin : model
      int n;
      int s0;
      logic [7:0] b;
      logic aw, sw, ack_s, req_s;
      if (rst_i) begin
         mq.delete();
         m_req = 0; m_pend = 0; m_pn = '0; m_bits = '0; m_addr = '0;
         m_prev = 0; m_mk = 0; m_mb = '0; m_en = 0; m_disc = 0;
      end else begin
         aw    = spr_cs & spr_write & spr_addr[1];
         sw    = spr_cs & spr_write & ~spr_addr[1];
         ack_s = mem_if.ack_i;
         b     = mem_if.dat_i[7:0];
         req_s = m_req;
         s0    = mq.size();
         if (get_bit_op_i || m_pend) begin
            n = m_pend ? int'(m_pn) : int'(num_bits_to_read_i);
            if (s0 >= n || m_mk || !m_en) begin
               m_bits = '0;
               for (int i = 0; i < n; i++) begin
                  if (mq.size() > 0) m_bits = {m_bits[30:0], mq.pop_front()};
                  else               m_bits = {m_bits[30:0], 1'b1};
               end
               m_pend = 0;
            end else begin
               m_pend = 1;
               m_pn   = 5'(n);
            end
         end
         if (req_s) begin
            if (ack_s) begin
               m_req = 0;
               if (!(m_disc || aw)) begin
                  m_addr = m_addr + 32'd1;
                  if (!m_prev) begin
                     for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
                     m_prev = (b == 8'hFF);
                  end else if (b == 8'h00) begin
                     m_prev = 0;
                  end else begin
                     for (int i = 0; i < 8; i++) if (mq.size() > 0) void'(mq.pop_back());
                     m_mk = 1; m_mb = b; m_prev = 0;
                  end
               end
               m_disc = 0;
            end
         end else if (m_en && !m_mk && s0 <= 24) begin
            m_req = 1;
         end
         if (aw) begin
            m_addr = spr_dat_i; mq.delete(); m_prev = 0; m_mk = 0; m_en = 1;
            m_disc = req_s && !ack_s;
         end
         if (sw) begin
            m_mk = 0; m_mb = '0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("bits_o", bits_o, m_bits);
         check("stall_cpu_o", 32'(stall_cpu_o), 32'(get_bit_op_i | m_pend));
         check("load_byte_o", 32'(mem_if.load_byte_o), 32'(m_req));
         check("vlx_addr_o", mem_if.vlx_addr_o, m_addr);
         if (spr_cs && !spr_write)
            check("spr_dat_o", spr_dat_o,
                  spr_addr[1] ? m_addr : {16'h0, m_mb, m_mk, 1'b0, 6'(mq.size())});
      end
   end

   task automatic spr_wr(input logic a1, input logic [31:0] d);
      @(posedge clk); #1;
      spr_write = 1'b1; spr_addr = {a1, 1'b0}; spr_dat_i = d;
      @(posedge clk); #1;
      spr_write = 1'b0; spr_addr = 2'b00;
   endtask

   task automatic spr_rd(input logic a1, output logic [31:0] d);
      spr_addr = {a1, 1'b0};
      #1;
      d = spr_dat_o;
      spr_addr = 2'b00;
   endtask

   task automatic do_get(input logic [4:0] n, output logic [31:0] r);
      int k;
      @(posedge clk); #1;
      get_bit_op_i = 1'b1; num_bits_to_read_i = n;
      @(posedge clk); #1;
      get_bit_op_i = 1'b0;
      k = 0;
      while (stall_cpu_o && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      if (stall_cpu_o) check("get_timeout", 32'(stall_cpu_o), 32'd0);
      r = bits_o;
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] r;
      int k;
      mem_if.ack_i = 1'b0;
      mem_if.dat_i = '0;
      mem_a[32'h1000] = 8'h12; mem_a[32'h1001] = 8'h34;
      mem_a[32'h1002] = 8'h56; mem_a[32'h1003] = 8'h78;
      mem_a[32'h1100] = 8'hFF; mem_a[32'h1101] = 8'h00; mem_a[32'h1102] = 8'hA5;
      mem_a[32'h1200] = 8'h5A; mem_a[32'h1201] = 8'hFF; mem_a[32'h1202] = 8'hD9;
      mem_a[32'h1300] = 8'hC3; mem_a[32'h1301] = 8'h96;
      mem_a[32'h1500] = 8'h11;
      mem_a[32'h2000] = 8'h3C;

      idle(3);
      rst_i = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("rst_bits", bits_o, 32'h0);
      check("rst_stall", 32'(stall_cpu_o), 32'h0);
      check("rst_load", 32'(mem_if.load_byte_o), 32'h0);
      spr_rd(1'b0, r); check("rst_status", r, 32'h0);
      spr_rd(1'b1, r); check("rst_addr", r, 32'h0);

      // Plain stream, prefetch to full, then gets with the next read held off
      spr_wr(1'b1, 32'h1000);
      idle(16);
      hold = 1'b1;
      spr_rd(1'b0, r); check("t1_fill32", r, 32'h20);
      do_get(5'd4,  r); check("t1_get4",  r, 32'h1);
      do_get(5'd8,  r); check("t1_get8",  r, 32'h23);
      do_get(5'd12, r); check("t1_get12", r, 32'h456);
      do_get(5'd8,  r); check("t1_get8b", r, 32'h78);
      spr_rd(1'b0, r); check("t1_status", r, 32'h0);
      spr_rd(1'b1, r); check("t1_addr", r, 32'h1004);

      // Restart during the held read, then byte stuffing
      spr_wr(1'b1, 32'h1100);
      hold = 1'b0;
      do_get(5'd16, r); check("t2_stuff", r, 32'hFFA5);

      // Marker detection and drain-mode padding
      spr_wr(1'b1, 32'h1200);
      idle(16);
      do_get(5'd8, r); check("t3_get_5a", r, 32'h5A);
      do_get(5'd8, r); check("t3_drain", r, 32'hFF);
      spr_rd(1'b0, r); check("t3_status", r, 32'h0000D980);
      spr_rd(1'b1, r); check("t3_addr", r, 32'h1203);
      idle(8);
      check("t3_no_fetch", 32'(mem_if.load_byte_o), 32'h0);
      spr_wr(1'b0, 32'h0);
      idle(4);
      spr_rd(1'b0, r); check("t3_clr", r & 32'hFF80, 32'h0);

      // Slow memory: get issued right after the address write
      lat = 5;
      spr_wr(1'b1, 32'h1300);
      do_get(5'd16, r); check("t4_slow", r, 32'hC396);
      do_get(5'd0, r);  check("t4_n0", r, 32'h0);

      // Address write while a read is in flight
      lat = 3;
      spr_wr(1'b1, 32'h1000);
      k = 0;
      while (!(mem_if.load_byte_o && mem_if.vlx_addr_o == 32'h1000) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("t5_req1000", 32'(mem_if.load_byte_o), 32'h1);
      spr_wr(1'b1, 32'h2000);
      do_get(5'd8, r); check("t5_discard", r, 32'h3C);

      // Reset during a request with a pending get
      lat = 20;
      spr_wr(1'b1, 32'h1500);
      @(posedge clk); #1;
      get_bit_op_i = 1'b1; num_bits_to_read_i = 5'd8;
      @(posedge clk); #1;
      get_bit_op_i = 1'b0;
      idle(4);
      check("t6_in_req", 32'(mem_if.load_byte_o), 32'h1);
      check("t6_pending", 32'(stall_cpu_o), 32'h1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      check("t6_stall", 32'(stall_cpu_o), 32'h0);
      check("t6_load", 32'(mem_if.load_byte_o), 32'h0);
      check("t6_bits", bits_o, 32'h0);
      spr_rd(1'b0, r); check("t6_status", r, 32'h0);
      idle(30);
      check("t6_no_fetch", 32'(mem_if.load_byte_o), 32'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
